// File: rtl/param_frame_rx.sv
// Serial parameter-frame receiver: 8N1 UART deserialiser, SOF/addr/data/checksum frame assembler
// and an Avalon-MM slave that holds the last valid frame plus status and error count for the CPU.
module param_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rxd,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        frame_rdy_n
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byteState_e;
  typedef enum logic [1:0] {F_SOF, F_ADDR, F_DATA, F_CSUM} frameState_e;

  logic rxdMeta_q, rxdSync_q, rxdPrev_q;

  byteState_e       byteState_q, byteState_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byteValid_q, byteValid_d;
  logic             framingErr_q, framingErr_d;

  frameState_e      frameState_q, frameState_d;
  logic [1:0]       dataIdx_q, dataIdx_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       addrAsm_q, addrAsm_d;
  logic [31:0]      dataAsm_q, dataAsm_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic             timeout;
  logic [7:0]       csumTotal;

  logic setValid, setOverrun, setCsum, setFrm, setTo, errInc;

  logic [4:0]  status_q, status_d;
  logic [15:0] errCnt_q, errCnt_d;
  logic [31:0] dataReg_q, dataReg_d;
  logic [7:0]  addrReg_q, addrReg_d;
  logic [31:0] readdata_q, readdata_d;
  logic        frameRdyN_q;
  logic        wrEn;

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxdMeta_q <= 1'b1;
      rxdSync_q <= 1'b1;
      rxdPrev_q <= 1'b1;
    end else begin
      rxdMeta_q <= rxd;
      rxdSync_q <= rxdMeta_q;
      rxdPrev_q <= rxdSync_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byteState_q  <= B_IDLE;
      bitCnt_q     <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      byteValid_q  <= 1'b0;
      framingErr_q <= 1'b0;
    end else begin
      byteState_q  <= byteState_d;
      bitCnt_q     <= bitCnt_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      byteValid_q  <= byteValid_d;
      framingErr_q <= framingErr_d;
    end
  end

  // Start bit is re-checked at its centre; later samples are a full bit apart from there.
  always_comb begin
    byteState_d  = byteState_q;
    bitCnt_d     = bitCnt_q + 1'b1;
    bitIdx_d     = bitIdx_q;
    shift_d      = shift_q;
    byteValid_d  = 1'b0;
    framingErr_d = 1'b0;
    case (byteState_q)
      B_IDLE: begin
        bitCnt_d = '0;
        if (rxdPrev_q && !rxdSync_q) byteState_d = B_START;
      end
      B_START: begin
        if (bitCnt_q == HALF_LAST) begin
          bitCnt_d    = '0;
          bitIdx_d    = '0;
          byteState_d = rxdSync_q ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          shift_d  = {rxdSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) byteState_d = B_STOP;
        end
      end
      B_STOP: begin
        if (bitCnt_q == BIT_LAST) begin
          byteState_d  = B_IDLE;
          byteValid_d  = rxdSync_q;
          framingErr_d = ~rxdSync_q;
        end
      end
      default: byteState_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frameState_q <= F_SOF;
      dataIdx_q    <= '0;
      sum_q        <= '0;
      addrAsm_q    <= '0;
      dataAsm_q    <= '0;
      gapCnt_q     <= '0;
    end else begin
      frameState_q <= frameState_d;
      dataIdx_q    <= dataIdx_d;
      sum_q        <= sum_d;
      addrAsm_q    <= addrAsm_d;
      dataAsm_q    <= dataAsm_d;
      gapCnt_q     <= gapCnt_d;
    end
  end

  // The gap counter only runs while the line is idle between bytes of a frame in progress.
  always_comb begin
    gapCnt_d = gapCnt_q;
    if (frameState_q == F_SOF || byteState_q != B_IDLE) gapCnt_d = '0;
    else if (gapCnt_q != GAP_LIMIT) gapCnt_d = gapCnt_q + 1'b1;
  end

  assign timeout = (frameState_q != F_SOF) && (byteState_q == B_IDLE) && (gapCnt_q == GAP_LIMIT);

  always_comb begin
    frameState_d = frameState_q;
    dataIdx_d    = dataIdx_q;
    sum_d        = sum_q;
    addrAsm_d    = addrAsm_q;
    dataAsm_d    = dataAsm_q;
    csumTotal    = sum_q + shift_q;
    setValid     = 1'b0;
    setOverrun   = 1'b0;
    setCsum      = 1'b0;
    setFrm       = 1'b0;
    setTo        = 1'b0;
    errInc       = 1'b0;
    if (timeout) begin
      frameState_d = F_SOF;
      setTo        = 1'b1;
      errInc       = 1'b1;
    end else if (framingErr_q && frameState_q != F_SOF) begin
      frameState_d = F_SOF;
      setFrm       = 1'b1;
      errInc       = 1'b1;
    end else if (byteValid_q) begin
      case (frameState_q)
        F_SOF: begin
          if (shift_q == SOF_BYTE) frameState_d = F_ADDR;
        end
        F_ADDR: begin
          addrAsm_d    = shift_q;
          sum_d        = shift_q;
          dataIdx_d    = '0;
          frameState_d = F_DATA;
        end
        F_DATA: begin
          dataAsm_d[dataIdx_q*8 +: 8] = shift_q;
          sum_d     = sum_q + shift_q;
          dataIdx_d = dataIdx_q + 1'b1;
          if (dataIdx_q == 2'd3) frameState_d = F_CSUM;
        end
        F_CSUM: begin
          frameState_d = F_SOF;
          if (csumTotal != 8'h00) begin
            setCsum = 1'b1;
            errInc  = 1'b1;
          end else if (status_q[0]) begin
            setOverrun = 1'b1;
          end else begin
            setValid = 1'b1;
          end
        end
        default: frameState_d = F_SOF;
      endcase
    end
  end

  // Register file: W1C status where a new set beats a simultaneous clear, saturating error count.
  always_comb begin
    wrEn     = chipselect && !write_n;
    status_d = status_q;
    if (wrEn && address == 2'd2) status_d = status_q & ~writedata[4:0];
    status_d = status_d | {setTo, setFrm, setCsum, setOverrun, setValid};

    errCnt_d = errCnt_q;
    if (wrEn && address == 2'd3) errCnt_d = errInc ? 16'd1 : 16'd0;
    else if (errInc && errCnt_q != 16'hFFFF) errCnt_d = errCnt_q + 16'd1;

    dataReg_d = dataReg_q;
    addrReg_d = addrReg_q;
    if (setValid) begin
      dataReg_d = dataAsm_q;
      addrReg_d = addrAsm_q;
    end

    case (address)
      2'd0:    readdata_d = dataReg_q;
      2'd1:    readdata_d = {24'd0, addrReg_q};
      2'd2:    readdata_d = {27'd0, status_q};
      default: readdata_d = {16'd0, errCnt_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q    <= '0;
      errCnt_q    <= '0;
      dataReg_q   <= '0;
      addrReg_q   <= '0;
      readdata_q  <= '0;
      frameRdyN_q <= 1'b1;
    end else begin
      status_q    <= status_d;
      errCnt_q    <= errCnt_d;
      dataReg_q   <= dataReg_d;
      addrReg_q   <= addrReg_d;
      readdata_q  <= readdata_d;
      frameRdyN_q <= ~status_q[0];
    end
  end

  assign readdata    = readdata_q;
  assign frame_rdy_n = frameRdyN_q;

endmodule

// File: tb/tb_param_frame_rx.sv
// Directed bench for param_frame_rx: UART frames driven bit by bit, registers checked over Avalon.
module tb_param_frame_rx;

  localparam int BIT = 16;
  localparam int TO  = 200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rxd;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        frame_rdy_n;

  int total = 0;
  int bad   = 0;
  int fallCount = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] expected;
  } regVec_t;

  param_frame_rx #(
    .CLKS_PER_BIT(BIT),
    .SOF_BYTE(8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rxd(rxd),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .frame_rdy_n(frame_rdy_n)
  );

  always #5 clk = ~clk;

  always @(negedge frame_rdy_n) if (reset_n === 1'b1) fallCount++;

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    waitCycles(1);
    d = readdata;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    waitCycles(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rxd = 1'b0;
    waitCycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      waitCycles(BIT);
    end
    rxd = stopBit;
    waitCycles(BIT);
    rxd = 1'b1;
    waitCycles(2 * BIT);
  endtask

  // Checksum is the two's complement of the byte sum over addr and data.
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d, input logic [7:0] csumDelta);
    logic [7:0] s;
    s = a + d[7:0] + d[15:8] + d[23:16] + d[31:24];
    sendByte(8'hA5, 1'b1);
    sendByte(a, 1'b1);
    for (int i = 0; i < 4; i++) sendByte(d[i*8 +: 8], 1'b1);
    sendByte(8'(8'h00 - s) + csumDelta, 1'b1);
    waitCycles(4);
  endtask

  task automatic checkRegs(input string tag, input logic [31:0] d, input logic [7:0] a,
                           input logic [4:0] s, input logic [15:0] e);
    regVec_t vec[4];
    logic [31:0] got;
    vec[0] = '{2'd0, d};
    vec[1] = '{2'd1, {24'd0, a}};
    vec[2] = '{2'd2, {27'd0, s}};
    vec[3] = '{2'd3, {16'd0, e}};
    for (int i = 0; i < 4; i++) begin
      readReg(vec[i].addr, got);
      checkOutput($sformatf("%s_reg%0d", tag, i), got, vec[i].expected);
    end
  endtask

  initial begin
    logic [7:0] t1Bytes[7];
    logic [31:0] got;
    t1Bytes = '{8'hA5, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDA};
    reset_n = 1'b0; rxd = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    waitCycles(5);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_rdy", {31'd0, frame_rdy_n}, 32'h1);
    reset_n = 1'b1;
    waitCycles(3);
    checkRegs("reset", 32'h0, 8'h00, 5'h00, 16'd0);

    $display("[TB] T1 valid frame");
    foreach (t1Bytes[i]) sendByte(t1Bytes[i], 1'b1);
    waitCycles(4);
    checkOutput("t1_rdy", {31'd0, frame_rdy_n}, 32'h0);
    checkOutput("t1_falls", fallCount, 1);
    checkRegs("t1", 32'h12345678, 8'h12, 5'h01, 16'd0);

    $display("[TB] T2 acknowledge and resend");
    writeReg(2'd2, 32'h1);
    waitCycles(2);
    checkOutput("t2_rdy_ack", {31'd0, frame_rdy_n}, 32'h1);
    readReg(2'd2, got);
    checkOutput("t2_status", got, 32'h0);
    foreach (t1Bytes[i]) sendByte(t1Bytes[i], 1'b1);
    waitCycles(4);
    checkOutput("t2_falls", fallCount, 2);
    checkOutput("t2_rdy", {31'd0, frame_rdy_n}, 32'h0);

    $display("[TB] T3 checksum error");
    writeReg(2'd2, 32'h1F);
    writeReg(2'd3, 32'h0);
    t1Bytes[6] = 8'hDB;
    foreach (t1Bytes[i]) sendByte(t1Bytes[i], 1'b1);
    waitCycles(4);
    checkOutput("t3_falls", fallCount, 2);
    checkOutput("t3_rdy", {31'd0, frame_rdy_n}, 32'h1);
    checkRegs("t3", 32'h12345678, 8'h12, 5'h04, 16'd1);

    $display("[TB] T4 overrun");
    writeReg(2'd2, 32'h1F);
    applyStimulus(8'h12, 32'h12345678, 8'h00);
    applyStimulus(8'h01, 32'hAABBCCDD, 8'h00);
    checkOutput("t4_falls", fallCount, 3);
    checkOutput("t4_rdy", {31'd0, frame_rdy_n}, 32'h0);
    checkRegs("t4", 32'h12345678, 8'h12, 5'h03, 16'd1);

    $display("[TB] T5 inter-byte timeout");
    writeReg(2'd2, 32'h1F);
    writeReg(2'd3, 32'h0);
    sendByte(8'hA5, 1'b1);
    sendByte(8'h12, 1'b1);
    waitCycles(2 * TO);
    checkRegs("t5_to", 32'h12345678, 8'h12, 5'h10, 16'd1);
    applyStimulus(8'h34, 32'hCAFEF00D, 8'h00);
    checkRegs("t5_ok", 32'hCAFEF00D, 8'h34, 5'h11, 16'd1);

    $display("[TB] T6 framing error and glitch");
    writeReg(2'd2, 32'h1F);
    sendByte(8'hA5, 1'b1);
    sendByte(8'h12, 1'b1);
    sendByte(8'h56, 1'b0);
    checkRegs("t6_frm", 32'hCAFEF00D, 8'h34, 5'h08, 16'd2);
    writeReg(2'd2, 32'h1F);
    sendByte(8'h77, 1'b0);
    checkRegs("t6_sof_frm", 32'hCAFEF00D, 8'h34, 5'h00, 16'd2);
    rxd = 1'b0;
    waitCycles(3);
    rxd = 1'b1;
    waitCycles(100);
    checkRegs("t6_glitch", 32'hCAFEF00D, 8'h34, 5'h00, 16'd2);

    $display("[TB] reset mid-frame");
    sendByte(8'hA5, 1'b1);
    rxd = 1'b0;
    waitCycles(20);
    reset_n = 1'b0;
    waitCycles(2);
    checkOutput("mid_rst_readdata", readdata, 32'h0);
    rxd = 1'b1;
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(3);
    checkRegs("mid_rst", 32'h0, 8'h00, 5'h00, 16'd0);
    applyStimulus(8'h56, 32'hDEADBEEF, 8'h00);
    checkOutput("post_rst_rdy", {31'd0, frame_rdy_n}, 32'h0);
    checkRegs("post_rst", 32'hDEADBEEF, 8'h56, 5'h01, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
